// File: rtl/spi_shift_frame_if.sv
// -----------------------------------------------------------------------------
// spi_shift_frame_if
//
// Bundles the data and strobe signals between the SPI bit-timing logic, the
// shift frame register and the byte/word side. clk and rst_n are kept outside
// as plain ports.
//
//   load        : parallel load strobe, starts a frame
//   parallel_in : word captured on load
//   shift_en    : one-cycle shift strobe
//   serial_in   : bit shifted in on shift_en
//   q           : register contents
//   serial_out  : outgoing bit, combinational from q
//   count       : shifts completed in the current frame
//   busy        : frame in progress
//   done        : one-cycle frame-complete pulse
//
// master : drives the strobes and data (bit-timing / word side)
// slave  : the shift frame register itself
// -----------------------------------------------------------------------------
interface spi_shift_frame_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             load;
   logic [WIDTH-1:0] parallel_in;
   logic             shift_en;
   logic             serial_in;
   logic [WIDTH-1:0] q;
   logic             serial_out;
   logic [CW-1:0]    count;
   logic             busy;
   logic             done;

   modport master (
      output load, parallel_in, shift_en, serial_in,
      input  q, serial_out, count, busy, done
   );

   modport slave (
      input  load, parallel_in, shift_en, serial_in,
      output q, serial_out, count, busy, done
   );
endinterface

// File: rtl/spi_shift_frame.sv
// -----------------------------------------------------------------------------
// spi_shift_frame
//
// WIDTH-bit shift register with parallel load, bit counter and frame-complete
// pulse. A frame is started by load and completes after WIDTH shift_en
// strobes. Shift direction is fixed at elaboration by MSB_FIRST.
//
// Ports:
//   clk    : system clock, all state updates on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : spi_shift_frame_if.slave (load, parallel_in, shift_en,
//            serial_in in; q, serial_out, count, busy, done out)
//
// Parameters:
//   WIDTH       : register / frame length, 2..32
//   MSB_FIRST   : 1 = shift toward MSB, serial_out = q[WIDTH-1]
//                 0 = shift toward LSB, serial_out = q[0]
//   RESET_VALUE : q after reset
// -----------------------------------------------------------------------------
module spi_shift_frame #(
   parameter int               WIDTH       = 8,
   parameter bit               MSB_FIRST   = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_shift_frame_if.slave  bus
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_r, state_nx;
   logic [WIDTH-1:0] q_r,     q_nx;
   logic [CW-1:0]    count_r, count_nx;
   logic             done_r,  done_nx;
   logic [WIDTH-1:0] q_shifted;

   // Serial_in enters the end opposite to the one feeding serial_out.
   always_comb begin
      if (MSB_FIRST) q_shifted = {q_r[WIDTH-2:0], bus.serial_in};
      else           q_shifted = {bus.serial_in, q_r[WIDTH-1:1]};
   end

   // NOTE: every signal gets a default before the branches so no path leaves
   // one unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_nx = state_r;
      q_nx     = q_r;
      count_nx = count_r;
      done_nx  = 1'b0;

      if (bus.load) begin
         // Load wins over shift_en in either state, including the final shift.
         q_nx     = bus.parallel_in;
         count_nx = '0;
         state_nx = SHIFT;
      end else if (state_r == SHIFT && bus.shift_en) begin
         q_nx     = q_shifted;
         count_nx = count_r + CW'(1);
         if (count_r == LAST_CNT) begin
            count_nx = FULL_CNT;
            state_nx = IDLE;
            done_nx  = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         q_r     <= RESET_VALUE;
         count_r <= '0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx;
         q_r     <= q_nx;
         count_r <= count_nx;
         done_r  <= done_nx;
      end
   end

   assign bus.q          = q_r;
   assign bus.serial_out = MSB_FIRST ? q_r[WIDTH-1] : q_r[0];
   assign bus.count      = count_r;
   assign bus.busy       = (state_r == SHIFT);
   assign bus.done       = done_r;

endmodule
